simple_tap_ctrl: RTL

Sequencer/arbiter for the 6-lane x 4-deep tap memory bank (192-bit word, six 32-bit lanes). It shares the bank between three requesters: the forward datapath (atomic read passes over all addresses), the bulk loader (full-width writes) and the weight-update path (single-lane sub-word writes). It drives the bank's tap interface and returns read data with valid/last qualifiers. Sits between the neuron stage control and the tap memory.

---
 rtl/simple_tap_ctrl_pkg.sv | 30 +++
 rtl/simple_tap_ctrl_if.sv | 61 ++++++
 rtl/simple_tap_ctrl_arb.sv | 45 ++++
 rtl/simple_tap_ctrl.sv | 125 ++++++++++++
 4 files changed

// File: rtl/simple_tap_ctrl_pkg.sv
// Shared types and constants for the tap memory bank sequencer.
// Bank geometry, FSM states and the packed bank-side strobe bundle.
package simple_tap_ctrl_pkg;

    localparam int LANES      = 6;
    localparam int LANE_W     = 32;
    localparam int DEPTH      = 4;
    localparam int ADDR_W     = $clog2(DEPTH);
    localparam int LANE_SEL_W = $clog2(LANES);
    localparam int WORD_W     = LANES * LANE_W;

    typedef enum logic {
        ST_IDLE,
        ST_READ
    } tap_ctrl_state_t;

    typedef struct packed {
        logic                  rd_vld;
        logic [ADDR_W-1:0]     rd_address;
        logic                  wr_vld;
        logic [ADDR_W-1:0]     wr_address;
        logic [WORD_W-1:0]     wr_data;
        logic                  sub_vld;
        logic [LANE_SEL_W-1:0] sub_addr;
        logic [LANE_W-1:0]     sub_data;
        logic                  inter;
        logic                  inter_first;
    } tap_int_192_4;

endpackage

// File: rtl/simple_tap_ctrl_if.sv
// Requester, bank and tap-return signals of the tap controller.
// slave is the controller side, master the requester/bank side.
interface simple_tap_ctrl_if;
    import simple_tap_ctrl_pkg::*;

    logic                  rd_req;
    logic                  rd_gnt;
    logic                  ld_vld;
    logic                  ld_rdy;
    logic [ADDR_W-1:0]     ld_addr;
    logic [WORD_W-1:0]     ld_data;
    logic                  up_vld;
    logic                  up_rdy;
    logic [ADDR_W-1:0]     up_addr;
    logic [LANE_SEL_W-1:0] up_lane;
    logic [LANE_W-1:0]     up_data;
    logic                  mem_rd_vld;
    logic [ADDR_W-1:0]     mem_rd_address;
    logic                  mem_wr_vld;
    logic [ADDR_W-1:0]     mem_wr_address;
    logic [WORD_W-1:0]     mem_wr_data;
    logic                  mem_sub_vld;
    logic [LANE_SEL_W-1:0] mem_sub_addr;
    logic [LANE_W-1:0]     mem_sub_data;
    logic                  mem_inter;
    logic                  mem_inter_first;
    logic [WORD_W-1:0]     mem_rd_data;
    logic                  tap_vld;
    logic                  tap_last;
    logic [ADDR_W-1:0]     tap_addr;
    logic [WORD_W-1:0]     tap_data;
    logic                  busy;
    logic [15:0]           pass_cnt;

    modport slave (
        input  rd_req, ld_vld, ld_addr, ld_data,
        input  up_vld, up_addr, up_lane, up_data,
        input  mem_rd_data,
        output rd_gnt, ld_rdy, up_rdy,
        output mem_rd_vld, mem_rd_address,
        output mem_wr_vld, mem_wr_address, mem_wr_data,
        output mem_sub_vld, mem_sub_addr, mem_sub_data,
        output mem_inter, mem_inter_first,
        output tap_vld, tap_last, tap_addr, tap_data,
        output busy, pass_cnt
    );

    modport master (
        output rd_req, ld_vld, ld_addr, ld_data,
        output up_vld, up_addr, up_lane, up_data,
        output mem_rd_data,
        input  rd_gnt, ld_rdy, up_rdy,
        input  mem_rd_vld, mem_rd_address,
        input  mem_wr_vld, mem_wr_address, mem_wr_data,
        input  mem_sub_vld, mem_sub_addr, mem_sub_data,
        input  mem_inter, mem_inter_first,
        input  tap_vld, tap_last, tap_addr, tap_data,
        input  busy, pass_cnt
    );

endinterface

// File: rtl/simple_tap_ctrl_arb.sv
// Idle-state arbiter: read vs write round-robin, load over update.
// last_was_rd alternates reads and writes so neither side starves.
module tap_ctrl_arb
    import simple_tap_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic idle_i,
    input  logic rd_req_i,
    input  logic ld_vld_i,
    input  logic up_vld_i,
    output logic gnt_rd_o,
    output logic gnt_ld_o,
    output logic gnt_up_o
);

    logic last_was_rd_q;
    logic last_was_rd_d;
    logic wr_pend;

    always_comb begin
        wr_pend  = ld_vld_i | up_vld_i;
        gnt_rd_o = idle_i & rd_req_i & (~wr_pend | ~last_was_rd_q);
        gnt_ld_o = idle_i & ~gnt_rd_o & ld_vld_i;
        gnt_up_o = idle_i & ~gnt_rd_o & ~ld_vld_i & up_vld_i;
    end

    always_comb begin
        last_was_rd_d = last_was_rd_q;
        if (gnt_rd_o) begin
            last_was_rd_d = 1'b1;
        end else if (gnt_ld_o | gnt_up_o) begin
            last_was_rd_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_was_rd_q <= 1'b0;
        end else begin
            last_was_rd_q <= last_was_rd_d;
        end
    end

endmodule

// File: rtl/simple_tap_ctrl.sv
// Tap memory bank sequencer: atomic read passes, loads and lane updates.
// Bank strobes are built in a packed bundle and fanned out to the flat ports.
module simple_tap_ctrl
    import simple_tap_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    simple_tap_ctrl_if.slave   bus
);

    localparam logic [ADDR_W-1:0]     LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [LANE_SEL_W-1:0] LANE_LIM  = LANE_SEL_W'(LANES);

    tap_ctrl_state_t   state_q;
    tap_ctrl_state_t   state_d;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d;
    logic              idle;
    logic              gnt_rd;
    logic              gnt_ld;
    logic              gnt_up;
    logic              issue_last;
    tap_int_192_4      mem_raw;
    tap_int_192_4      mem;

    logic              tap_vld_q;
    logic              tap_last_q;
    logic [ADDR_W-1:0] tap_addr_q;
    logic [15:0]       pass_cnt_q;
    logic [15:0]       pass_cnt_d;

    assign idle = (state_q == ST_IDLE) & ~reset;

    tap_ctrl_arb u_arb (
        .clk      (clk),
        .reset    (reset),
        .idle_i   (idle),
        .rd_req_i (bus.rd_req),
        .ld_vld_i (bus.ld_vld),
        .up_vld_i (bus.up_vld),
        .gnt_rd_o (gnt_rd),
        .gnt_ld_o (gnt_ld),
        .gnt_up_o (gnt_up)
    );

    always_comb begin
        state_d  = state_q;
        rd_ptr_d = rd_ptr_q;
        mem_raw  = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (gnt_rd) begin
                    mem_raw.rd_vld      = 1'b1;
                    mem_raw.inter       = 1'b1;
                    mem_raw.inter_first = 1'b1;
                    rd_ptr_d            = ADDR_W'(1);
                    state_d             = ST_READ;
                end else if (gnt_ld) begin
                    mem_raw.wr_vld     = 1'b1;
                    mem_raw.wr_address = bus.ld_addr;
                    mem_raw.wr_data    = bus.ld_data;
                end else if (gnt_up && (bus.up_lane < LANE_LIM)) begin
                    mem_raw.sub_vld    = 1'b1;
                    mem_raw.sub_addr   = bus.up_lane;
                    mem_raw.sub_data   = bus.up_data;
                    mem_raw.wr_address = bus.up_addr;
                end
            end
            ST_READ: begin
                mem_raw.rd_vld     = 1'b1;
                mem_raw.rd_address = rd_ptr_q;
                mem_raw.inter      = 1'b1;
                rd_ptr_d           = rd_ptr_q + ADDR_W'(1);
                if (rd_ptr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // A reset cycle aborts any pass without issuing to the bank.
    assign mem        = reset ? '0 : mem_raw;
    assign issue_last = mem.rd_vld & (mem.rd_address == LAST_ADDR);
    assign pass_cnt_d = issue_last ? pass_cnt_q + 16'd1 : pass_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            rd_ptr_q   <= '0;
            tap_vld_q  <= 1'b0;
            tap_last_q <= 1'b0;
            tap_addr_q <= '0;
            pass_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rd_ptr_q   <= rd_ptr_d;
            tap_vld_q  <= mem.rd_vld;
            tap_last_q <= issue_last;
            tap_addr_q <= mem.rd_address;
            pass_cnt_q <= pass_cnt_d;
        end
    end

    assign bus.rd_gnt          = gnt_rd;
    assign bus.ld_rdy          = gnt_ld;
    assign bus.up_rdy          = gnt_up;
    assign bus.mem_rd_vld      = mem.rd_vld;
    assign bus.mem_rd_address  = mem.rd_address;
    assign bus.mem_wr_vld      = mem.wr_vld;
    assign bus.mem_wr_address  = mem.wr_address;
    assign bus.mem_wr_data     = mem.wr_data;
    assign bus.mem_sub_vld     = mem.sub_vld;
    assign bus.mem_sub_addr    = mem.sub_addr;
    assign bus.mem_sub_data    = mem.sub_data;
    assign bus.mem_inter       = mem.inter;
    assign bus.mem_inter_first = mem.inter_first;
    assign bus.tap_vld         = tap_vld_q;
    assign bus.tap_last        = tap_last_q;
    assign bus.tap_addr        = tap_addr_q;
    assign bus.tap_data        = tap_vld_q ? bus.mem_rd_data : '0;
    assign bus.busy            = gnt_rd | ((state_q == ST_READ) & ~reset);
    assign bus.pass_cnt        = pass_cnt_q;

endmodule
